// File: rtl/riscv_regfile_mp.sv
// RISC-V integer register file: one write port, NUM_READ read ports, hardwired x0,
// optional write-to-read bypass, optional registered read stage and a post-reset clear sequencer.
module riscv_regfile_mp #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGISTER = 32,
   parameter int NUM_READ     = 2,
   parameter int BYPASS       = 1,
   parameter int READ_REG     = 0
) (
   input  logic                                         clk,
   input  logic                                         reset,
   input  logic                                         reg_wen,
   input  logic [$clog2(NUM_REGISTER)-1:0]              addr_d,
   input  logic [DATA_WIDTH-1:0]                        data_d,
   input  logic [NUM_READ*$clog2(NUM_REGISTER)-1:0]     addr_r,
   output logic [NUM_READ*DATA_WIDTH-1:0]               data_r,
   output logic                                         ready
);

   localparam int SEL_WIDTH = $clog2(NUM_REGISTER);

   typedef enum logic [1:0] {
      ST_CLEAR = 2'b01,
      ST_RUN   = 2'b10
   } state_t;

   state_t                 state;
   state_t                 state_next;
   logic [SEL_WIDTH-1:0]   clr_ptr;
   logic [SEL_WIDTH-1:0]   clr_ptr_next;
   logic                   running;
   logic [DATA_WIDTH-1:0]  regs [NUM_REGISTER];

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_ptr <= SEL_WIDTH'(1);
      end else begin
         state   <= state_next;
         clr_ptr <= clr_ptr_next;
      end
   end

   // The terminal pointer value is the exit condition, so the pointer never wraps.
   always_comb begin
      state_next   = state;
      clr_ptr_next = clr_ptr;
      case (state)
         ST_CLEAR: begin
            if (clr_ptr == SEL_WIDTH'(NUM_REGISTER - 1)) begin
               state_next = ST_RUN;
            end else begin
               clr_ptr_next = clr_ptr + SEL_WIDTH'(1);
            end
         end
         ST_RUN: begin
            state_next = ST_RUN;
         end
         default: begin
            state_next   = ST_CLEAR;
            clr_ptr_next = SEL_WIDTH'(1);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      regs[0] <= '0;
      if (!reset) begin
         if (state == ST_CLEAR) begin
            regs[clr_ptr] <= '0;
         end else if (state == ST_RUN && reg_wen && addr_d != '0) begin
            regs[addr_d] <= data_d;
         end
      end
   end

   assign running = (state == ST_RUN) && !reset;
   assign ready   = (state == ST_RUN);

   for (genvar i = 0; i < NUM_READ; i++) begin : g_port
      logic [SEL_WIDTH-1:0]  sel;
      logic [DATA_WIDTH-1:0] rd_val;

      assign sel = addr_r[i*SEL_WIDTH +: SEL_WIDTH];

      // Zero while clearing or in reset so stale contents never leak out.
      assign rd_val = (!running || sel == '0)                      ? '0     :
                      (BYPASS != 0 && reg_wen && addr_d == sel)    ? data_d :
                                                                     regs[sel];

      if (READ_REG != 0) begin : g_reg
         logic [DATA_WIDTH-1:0] rd_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               rd_q <= '0;
            end else begin
               rd_q <= rd_val;
            end
         end
         assign data_r[i*DATA_WIDTH +: DATA_WIDTH] = rd_q;
      end else begin : g_comb
         assign data_r[i*DATA_WIDTH +: DATA_WIDTH] = rd_val;
      end
   end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Scoreboard bench for riscv_regfile_mp: a default instance (combinational, bypass) and a
// 16x64, 3-port, registered, non-bypassed instance, both checked against an array model.
module tb_riscv_regfile_mp;

   localparam int NREG_A = 32;
   localparam int NREG_B = 16;

   typedef struct packed {
      logic        rdy_a;
      logic        rdy_b;
      logic [63:0] d_a;
   } exp_a_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         reg_wen = 1'b0;
   logic [4:0]   addr_d_a = '0;
   logic [63:0]  data_d_b = '0;
   logic [9:0]   addr_r_a = '0;
   logic [11:0]  addr_r_b = '0;
   logic [63:0]  data_r_a;
   logic [191:0] data_r_b;
   logic         ready_a;
   logic         ready_b;

   logic [31:0]  mem_a [NREG_A];
   logic [63:0]  mem_b [NREG_B];
   int           clr_a = NREG_A - 1;
   int           clr_b = NREG_B - 1;

   exp_a_t       qa [$];
   logic [191:0] qb [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   riscv_regfile_mp #(
      .DATA_WIDTH(32), .NUM_REGISTER(NREG_A), .NUM_READ(2), .BYPASS(1), .READ_REG(0)
   ) dut_a (
      .clk(clk), .reset(reset), .reg_wen(reg_wen), .addr_d(addr_d_a),
      .data_d(data_d_b[31:0]), .addr_r(addr_r_a), .data_r(data_r_a), .ready(ready_a)
   );

   riscv_regfile_mp #(
      .DATA_WIDTH(64), .NUM_REGISTER(NREG_B), .NUM_READ(3), .BYPASS(0), .READ_REG(1)
   ) dut_b (
      .clk(clk), .reset(reset), .reg_wen(reg_wen), .addr_d(addr_d_a[3:0]),
      .data_d(data_d_b), .addr_r(addr_r_b), .data_r(data_r_b), .ready(ready_b)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, queue what each instance must show, then advance the model.
   task automatic applyStimulus(input logic rst, input logic wen, input logic [4:0] ad,
                                input logic [63:0] dd, input logic [9:0] ara, input logic [11:0] arb);
      exp_a_t       ea;
      logic [191:0] eb;
      logic [4:0]   sa;
      logic [3:0]   sb;
      @(posedge clk);
      #1;
      reset    = rst;
      reg_wen  = wen;
      addr_d_a = ad;
      data_d_b = dd;
      addr_r_a = ara;
      addr_r_b = arb;

      ea.rdy_a = (clr_a == 0);
      ea.rdy_b = (clr_b == 0);
      ea.d_a   = '0;
      for (int i = 0; i < 2; i++) begin
         sa = ara[i*5 +: 5];
         if (rst || clr_a != 0 || sa == 0)  ea.d_a[i*32 +: 32] = '0;
         else if (wen && ad == sa)          ea.d_a[i*32 +: 32] = dd[31:0];
         else                               ea.d_a[i*32 +: 32] = mem_a[sa];
      end
      eb = '0;
      for (int i = 0; i < 3; i++) begin
         sb = arb[i*4 +: 4];
         if (rst || clr_b != 0 || sb == 0)  eb[i*64 +: 64] = '0;
         else                               eb[i*64 +: 64] = mem_b[sb];
      end
      qa.push_back(ea);
      qb.push_back(eb);

      if (rst) begin
         for (int r = 0; r < NREG_A; r++) mem_a[r] = '0;
         for (int r = 0; r < NREG_B; r++) mem_b[r] = '0;
         clr_a = NREG_A - 1;
         clr_b = NREG_B - 1;
      end else begin
         if (clr_a != 0) clr_a--;
         else if (wen && ad != 0) mem_a[ad] = dd[31:0];
         if (clr_b != 0) clr_b--;
         else if (wen && ad[3:0] != 0) mem_b[ad[3:0]] = dd;
      end
   endtask

   // Monitor: instance A is combinational (same cycle), instance B lags by one cycle.
   initial begin
      exp_a_t       e;
      logic [191:0] b;
      forever begin
         @(negedge clk);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            checkOutput("ready_a", 64'(ready_a), 64'(e.rdy_a));
            checkOutput("ready_b", 64'(ready_b), 64'(e.rdy_b));
            for (int i = 0; i < 2; i++)
               checkOutput($sformatf("data_r_a[%0d]", i), 64'(data_r_a[i*32 +: 32]), 64'(e.d_a[i*32 +: 32]));
         end
         if (qb.size() >= 2) begin
            b = qb.pop_front();
            for (int i = 0; i < 3; i++)
               checkOutput($sformatf("data_r_b[%0d]", i), data_r_b[i*64 +: 64], b[i*64 +: 64]);
         end
      end
   end

   initial begin
      logic [4:0]  ad;
      logic [9:0]  ara;
      logic [11:0] arb;
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0);
      // Clear with writes to x4 attempted throughout; reads of x4/x31 stay zero.
      for (int c = 0; c < 34; c++)
         applyStimulus(0, (c < 14), 5'd4, 64'h1, {5'd31, 5'd4}, {4'd15, 4'd4, 4'd4});
      applyStimulus(0, 0, 0, 0, {5'd31, 5'd4}, {4'd0, 4'd4, 4'd4});
      applyStimulus(0, 1, 5'd7, 64'h12345678, {5'd0, 5'd7}, 0);
      applyStimulus(0, 1, 5'd0, 64'hFFFFFFFF_FFFFFFFF, {5'd0, 5'd7}, {4'd0, 4'd7, 4'd7});
      applyStimulus(0, 1, 5'd3, 64'hA5A5A5A5, {5'd0, 5'd3}, {4'd0, 4'd7, 4'd3});
      applyStimulus(0, 1, 5'd15, 64'hFFFF_FFFF_FFFF_FFFF, {5'd3, 5'd15}, {4'd15, 4'd7, 4'd7});
      applyStimulus(0, 1, 5'd5, 64'hDEADBEEF, {5'd15, 5'd5}, {4'd15, 4'd5, 4'd3});
      applyStimulus(0, 0, 0, 0, {5'd15, 5'd5}, {4'd15, 4'd5, 4'd3});
      applyStimulus(1, 0, 0, 0, {5'd31, 5'd5}, {4'd15, 4'd5, 4'd3});
      for (int c = 0; c < 33; c++)
         applyStimulus(0, 0, 0, 0, {5'd31, 5'd5}, {4'd15, 4'd5, 4'd7});
      // Reset again at clear edge 10.
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 10; c++) applyStimulus(0, 1, 5'd9, 64'h99, {5'd9, 5'd9}, {4'd9, 4'd9, 4'd9});
      applyStimulus(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 33; c++) applyStimulus(0, 0, 0, 0, {5'd9, 5'd31}, {4'd9, 4'd0, 4'd15});
      // Random traffic with frequent address collisions and rare resets.
      for (int c = 0; c < 900; c++) begin
         ad  = 5'($urandom);
         ara = 10'($urandom);
         arb = 12'($urandom);
         if ($urandom_range(0, 1) == 1) ara[4:0] = ad;
         if ($urandom_range(0, 1) == 1) arb[3:0] = ad[3:0];
         applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom), ad,
                       {$urandom, $urandom}, ara, arb);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      checkOutput("qa_drained", 64'(qa.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
